// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_types_pkg : shared multiply/divide op and state encodings  rev 1.0 |
// +-----------------------------------------------------------------------+
package cpu_types_pkg;

   typedef enum logic [1:0] {
      MD_MULTU = 2'b00,
      MD_MULT  = 2'b01,
      MD_DIVU  = 2'b10,
      MD_DIV   = 2'b11
   } muldiv_op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_t;

   localparam int MULDIV_ITER = 32;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_muldiv_unit_if : request/result bundle of the mul/div unit  rev 1.0 |
// +-----------------------------------------------------------------------+
interface ex_muldiv_unit_if #(
   parameter int DATA_W = 32
);
   import cpu_types_pkg::*;

   logic              start;
   muldiv_op_t        op;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic              flush;
   logic              stall;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              div0;

   modport master (
      output start, op, rs_val, rt_val, flush,
      input  stall, busy, done, hi, lo, div0
   );

   modport slave (
      input  start, op, rs_val, rt_val, flush,
      output stall, busy, done, hi, lo, div0
   );

endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_step : one radix-2 shift-add / restoring shift-sub      rev 1.0 |
// +-----------------------------------------------------------------------+
module muldiv_step #(
   parameter int DATA_W = 32
)(
   input  logic              is_div_i,
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] q_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] acc_o,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] addend;
   logic [DATA_W:0] rem;
   logic [DATA_W:0] diff;

   assign sum    = {1'b0, acc_i} + {1'b0, b_i};
   assign addend = q_i[0] ? sum : {1'b0, acc_i};
   assign rem    = {acc_i, q_i[DATA_W-1]};
   assign diff   = rem - {1'b0, b_i};

   always_comb begin
      acc_o = acc_i;
      q_o   = q_i;
      if (is_div_i) begin
         // diff MSB set means the trial subtract borrowed: restore
         acc_o = diff[DATA_W] ? rem[DATA_W-1:0] : diff[DATA_W-1:0];
         q_o   = {q_i[DATA_W-2:0], ~diff[DATA_W]};
      end else begin
         acc_o = addend[DATA_W:1];
         q_o   = {addend[0], q_i[DATA_W-1:1]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ex_muldiv_unit : iterative 32-bit MULT/MULTU/DIV/DIVU, EX stage rev 1.0|
// | MULDIV_SIGNED_EN enables signed MULT/DIV (else treated as unsigned)    |
// +-----------------------------------------------------------------------+
module ex_muldiv_unit
   import cpu_types_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ITER   = DATA_W
)(
   input  logic           CLK,
   input  logic           RST,
   ex_muldiv_unit_if.slave bus
);

`ifdef MULDIV_SIGNED_EN
   localparam logic SIGNED_EN = 1'b1;
`else
   localparam logic SIGNED_EN = 1'b0;
`endif

   muldiv_state_t     state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, q_q, q_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic              is_div_q, is_div_d, sgn_q, sgn_d;
   logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

   logic [DATA_W-1:0]   acc_step, q_step, a_abs, b_abs, quo_s, rem_s;
   logic [2*DATA_W-1:0] prod_s;

   muldiv_step #(.DATA_W(DATA_W)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .q_i      (q_q),
      .b_i      (b_q),
      .acc_o    (acc_step),
      .q_o      (q_step)
   );

   assign a_abs  = (sgn_q && a_q[DATA_W-1]) ? -a_q : a_q;
   assign b_abs  = (sgn_q && b_q[DATA_W-1]) ? -b_q : b_q;
   assign prod_s = neg_res_q ? -{acc_q, q_q} : {acc_q, q_q};
   assign quo_s  = neg_res_q ? -q_q : q_q;
   assign rem_s  = neg_rem_q ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      q_d       = q_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      sgn_d     = sgn_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               state_d  = PREP;
               a_d      = bus.rs_val;
               b_d      = bus.rt_val;
               is_div_d = bus.op[1];
               sgn_d    = SIGNED_EN & bus.op[0];
            end
         end
         PREP: begin
            acc_d     = '0;
            q_d       = a_abs;
            b_d       = b_abs;
            neg_res_d = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            neg_rem_d = sgn_q & a_q[DATA_W-1];
            cnt_d     = 6'(ITER - 1);
            state_d   = CALC;
         end
         CALC: begin
            acc_d = acc_step;
            q_d   = q_step;
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd0) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            div0_d  = 1'b0;
            if (is_div_q && (b_q == '0)) begin
               lo_d   = '1;
               hi_d   = a_q;
               div0_d = 1'b1;
            end else if (is_div_q) begin
               lo_d = quo_s;
               hi_d = rem_s;
            end else begin
               hi_d = prod_s[2*DATA_W-1:DATA_W];
               lo_d = prod_s[DATA_W-1:0];
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // An abort must not disturb the architecturally visible result
      if ((state_q != IDLE) && bus.flush) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         div0_d  = div0_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         sgn_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         sgn_q     <= sgn_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
      end
   end

   assign bus.stall = ((state_q == IDLE) && bus.start && !bus.flush) ||
                      (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.div0  = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_ex_muldiv_unit : directed vector bench for ex_muldiv_unit   rev 1.0 |
// +-----------------------------------------------------------------------+
module tb_ex_muldiv_unit;
   import cpu_types_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ex_muldiv_unit_if #(.DATA_W(32)) bus ();

   ex_muldiv_unit #(.DATA_W(32)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      muldiv_op_t op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        d0;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issues one op at cycle k=0 and observes 45 cycles; start re-pulses at k==tog.
   task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input int tog, output int lat, output int nd, output int sbad,
                         output logic [31:0] h, output logic [31:0] l, output logic d0);
      lat = -1; nd = 0; sbad = 0; h = '0; l = '0; d0 = 1'b0;
      @(negedge clk);
      bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
      for (int k = 0; k < 45; k++) begin
         #1;
         if (bus.stall !== (k <= 34)) sbad++;
         if (bus.done === 1'b1) begin
            nd++;
            if (lat < 0) begin
               lat = k; h = bus.hi; l = bus.lo; d0 = bus.div0;
            end
         end
         @(negedge clk);
         bus.start = (k + 1 == tog);
      end
      bus.start = 1'b0;
   endtask

   function automatic logic [31:0] sel(input logic [31:0] s, input logic [31:0] u);
`ifdef MULDIV_SIGNED_EN
      return s;
`else
      return u;
`endif
   endfunction

   initial begin
      int lat, nd, sbad, ndone;
      logic [31:0] h, l;
      logic d0;
      checks = 0; errors = 0;
      rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
      bus.op = MD_MULTU; bus.rs_val = '0; bus.rt_val = '0;

      vecs[0]  = '{"multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{"mult_m3x7", MD_MULT, 32'hFFFFFFFD, 32'd7, sel(32'hFFFFFFFF, 32'h6), 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{"div_m7d2", MD_DIV, 32'hFFFFFFF9, 32'd2, sel(32'hFFFFFFFF, 32'h1),
                   sel(32'hFFFFFFFD, 32'h7FFFFFFC), 1'b0};
      vecs[3]  = '{"divu_7d0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{"multu_2x3a", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0};
      vecs[5]  = '{"div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, sel(32'h0, 32'h80000000),
                   sel(32'h80000000, 32'h0), 1'b0};
      vecs[6]  = '{"div_m7d0", MD_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{"mult_min2", MD_MULT, 32'h80000000, 32'd2, sel(32'hFFFFFFFF, 32'h1), 32'h0, 1'b0};
      vecs[8]  = '{"div_7dm2", MD_DIV, 32'd7, 32'hFFFFFFFE, sel(32'h1, 32'h7), sel(32'hFFFFFFFD, 32'h0), 1'b0};
      vecs[9]  = '{"multu_x0", MD_MULTU, 32'h12345678, 32'd0, 32'h0, 32'h0, 1'b0};
      vecs[10] = '{"multu_2x3b", MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_hi", 64'(bus.hi), 64'h0);
      chk("rst_lo", 64'(bus.lo), 64'h0);
      chk("rst_flags", {60'h0, bus.busy, bus.stall, bus.done, bus.div0}, 64'h0);

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat, nd, sbad, h, l, d0);
         chk({vecs[i].name, "_lat"}, 64'(lat), 64'd35);
         chk({vecs[i].name, "_ndone"}, 64'(nd), 64'd1);
         chk({vecs[i].name, "_stall"}, 64'(sbad), 64'd0);
         chk({vecs[i].name, "_hi"}, 64'(h), 64'(vecs[i].hi));
         chk({vecs[i].name, "_lo"}, 64'(l), 64'(vecs[i].lo));
         chk({vecs[i].name, "_div0"}, 64'(d0), 64'(vecs[i].d0));
      end

      // Flush a DIVU 100/7 in CALC; result registers must keep 0/6
      @(negedge clk);
      bus.op = MD_DIVU; bus.rs_val = 32'd100; bus.rt_val = 32'd7; bus.start = 1'b1;
      ndone = 0;
      for (int k = 0; k < 45; k++) begin
         #1;
         if (bus.done === 1'b1) ndone++;
         if (k == 10) chk("flush_busy_before", 64'(bus.busy), 64'd1);
         if (k == 11) chk("flush_idle_after", 64'(bus.busy), 64'd0);
         @(negedge clk);
         bus.start = 1'b0;
         bus.flush = (k + 1 == 10);
      end
      chk("flush_no_done", 64'(ndone), 64'd0);
      chk("flush_hi", 64'(bus.hi), 64'd0);
      chk("flush_lo", 64'(bus.lo), 64'd6);

      run_op(MD_DIVU, 32'd100, 32'd7, -1, lat, nd, sbad, h, l, d0);
      chk("reissue_lat", 64'(lat), 64'd35);
      chk("reissue_lo", 64'(l), 64'd14);
      chk("reissue_hi", 64'(h), 64'd2);

      // start re-pulsed at T+5 while busy must not spawn a second operation
      run_op(MD_DIVU, 32'd9, 32'd0, 5, lat, nd, sbad, h, l, d0);
      chk("tog_lat", 64'(lat), 64'd35);
      chk("tog_ndone", 64'(nd), 64'd1);
      chk("tog_stall", 64'(sbad), 64'd0);
      chk("tog_hilo", {h, l}, {32'd9, 32'hFFFFFFFF});
      chk("tog_div0", 64'(d0), 64'd1);

      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MULTU;
      #1 chk("fs_stall", 64'(bus.stall), 64'd0);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      #1 chk("fs_busy", 64'(bus.busy), 64'd0);

      // Synchronous reset in the middle of an operation
      @(negedge clk);
      bus.op = MD_MULTU; bus.rs_val = 32'd5; bus.rt_val = 32'd6; bus.start = 1'b1;
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         rst = (k + 1 == 20);
      end
      #1;
      chk("midrst_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("midrst_flags", {60'h0, bus.busy, bus.stall, bus.done, bus.div0}, 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
